// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states, default protection.
// Purely declarative, no latency.
// No flow control of its own.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRITE_RESP,
    READ_ADDR,
    READ_DATA,
    DONE
  } state_t;

  // States in which a bus transaction is outstanding and the watchdog runs.
  function automatic logic is_busy(state_t s);
    return (s == WRITE) || (s == WRITE_RESP) || (s == READ_ADDR) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/axi4_lite_master_if.sv
// Core request/response port plus the AXI4-Lite master channels.
// Wires only, no latency.
// valid/ready handshakes on every channel.
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // core side
  logic                    req_valid;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_timeout;
  // AXI4-Lite side
  logic                    m_AWVALID;
  logic [2:0]              m_AWPROT;
  logic [ADDR_WIDTH-1:0]   m_AWADDR;
  logic                    m_AWREADY;
  logic                    m_WVALID;
  logic [DATA_WIDTH-1:0]   m_WDATA;
  logic [DATA_WIDTH/8-1:0] m_WSTRB;
  logic                    m_WREADY;
  logic                    m_BVALID;
  logic [1:0]              m_BRESP;
  logic                    m_BREADY;
  logic                    m_ARVALID;
  logic [2:0]              m_ARPROT;
  logic [ADDR_WIDTH-1:0]   m_ARADDR;
  logic                    m_ARREADY;
  logic                    m_RVALID;
  logic [DATA_WIDTH-1:0]   m_RDATA;
  logic [1:0]              m_RRESP;
  logic                    m_RREADY;

  // View of the initiator block itself.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_AWVALID, m_AWPROT, m_AWADDR, input m_AWREADY,
    output m_WVALID, m_WDATA, m_WSTRB, input m_WREADY,
    input  m_BVALID, m_BRESP, output m_BREADY,
    output m_ARVALID, m_ARPROT, m_ARADDR, input m_ARREADY,
    input  m_RVALID, m_RDATA, m_RRESP, output m_RREADY
  );

  // View of the core requester plus the AXI target.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_AWVALID, m_AWPROT, m_AWADDR, output m_AWREADY,
    input  m_WVALID, m_WDATA, m_WSTRB, output m_WREADY,
    output m_BVALID, m_BRESP, input m_BREADY,
    input  m_ARVALID, m_ARPROT, m_ARADDR, output m_ARREADY,
    output m_RVALID, m_RDATA, m_RRESP, input m_RREADY
  );
endinterface

// File: rtl/axi4_lite_timeout.sv
// Transaction watchdog: expire_o pulses on the enabled cycle that brings the count to TIMEOUT_CYCLES.
// Combinational expire from a registered count; clear takes priority over enable.
// No flow control; TIMEOUT_CYCLES=0 never expires.
module axi4_lite_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on acceptance, otherwise count busy cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a core request/response port to AXI.
// Zero-wait target: accept cycle 0, address/data cycle 1, B or R cycle 2, rsp_valid cycle 3.
// req_ready only in IDLE (not while draining a late beat); AXI valids held until ready or timeout.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic iCLK,
  input  logic iRST,
  axi4_lite_master_if.master bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state_q, state_d;
  logic                    run_q;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timeout_q, timeout_d;

  logic req_rdy, aw_vld, w_vld, b_rdy, ar_vld, r_rdy, rsp_vld;
  logic aw_hs, w_hs, tmo_clr, tmo_en, tmo_expire;

  assign tmo_en = is_busy(state_q);

  axi4_lite_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  // Next-state, captured-data and channel-control decode.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    drain_d   = drain_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    req_rdy   = 1'b0;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    b_rdy     = 1'b0;
    ar_vld    = 1'b0;
    r_rdy     = 1'b0;
    rsp_vld   = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    tmo_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        // A beat left over from a timed-out transaction is swallowed here.
        req_rdy = run_q && !drain_q;
        b_rdy   = drain_q;
        r_rdy   = drain_q;
        if (drain_q && (bus.m_BVALID || bus.m_RVALID)) drain_d = 1'b0;
        if (bus.req_valid && req_rdy) begin
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          wstrb_d   = bus.req_wstrb;
          rdata_d   = '0;
          resp_d    = RESP_OKAY;
          timeout_d = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          tmo_clr   = 1'b1;
          state_d   = bus.req_write ? WRITE : READ_ADDR;
        end
      end
      WRITE: begin
        aw_vld    = !aw_done_q;
        w_vld     = !w_done_q;
        aw_hs     = aw_vld && bus.m_AWREADY;
        w_hs      = w_vld && bus.m_WREADY;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WRITE_RESP;
        end else if (tmo_expire) begin
          state_d   = DONE;
          resp_d    = RESP_SLVERR;
          timeout_d = 1'b1;
        end
      end
      WRITE_RESP: begin
        b_rdy = 1'b1;
        if (bus.m_BVALID) begin
          resp_d  = bus.m_BRESP;
          state_d = DONE;
        end else if (tmo_expire) begin
          state_d   = DONE;
          resp_d    = RESP_SLVERR;
          timeout_d = 1'b1;
          drain_d   = 1'b1;
        end
      end
      READ_ADDR: begin
        ar_vld = 1'b1;
        if (bus.m_ARREADY) begin
          state_d = READ_DATA;
        end else if (tmo_expire) begin
          state_d   = DONE;
          resp_d    = RESP_SLVERR;
          timeout_d = 1'b1;
        end
      end
      READ_DATA: begin
        r_rdy = 1'b1;
        if (bus.m_RVALID) begin
          rdata_d = bus.m_RDATA;
          resp_d  = bus.m_RRESP;
          state_d = DONE;
        end else if (tmo_expire) begin
          state_d   = DONE;
          resp_d    = RESP_SLVERR;
          timeout_d = 1'b1;
          drain_d   = 1'b1;
        end
      end
      DONE: begin
        rsp_vld = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; run_q keeps req_ready low while in reset.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      drain_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      drain_q   <= drain_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.req_ready   = req_rdy;
  assign bus.rsp_valid   = rsp_vld;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_resp    = resp_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.m_AWVALID   = aw_vld;
  assign bus.m_AWPROT    = PROT_DEFAULT;
  assign bus.m_AWADDR    = addr_q;
  assign bus.m_WVALID    = w_vld;
  assign bus.m_WDATA     = wdata_q;
  assign bus.m_WSTRB     = wstrb_q;
  assign bus.m_BREADY    = b_rdy;
  assign bus.m_ARVALID   = ar_vld;
  assign bus.m_ARPROT    = PROT_DEFAULT;
  assign bus.m_ARADDR    = addr_q;
  assign bus.m_RREADY    = r_rdy;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench: configurable AXI4-Lite target model, response scoreboard.
// Responses are timestamped in cycles relative to request acceptance.
// Target stalls are controlled by per-test knobs.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;

  axi4_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          cyc;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  rsp_t mon_r;
  int   rsp_cnt = 0;
  int   aw_hs_cyc = -1, w_hs_cyc = -1, ar_hs_cyc = -1, r_hs_cyc = -1;
  logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;

  // ---------------- target model ----------------
  int          aw_lat = 0, ar_lat = 0, w_gap = 0;
  bit          w_after_aw = 0, b_en = 1, r_en = 1;
  logic [1:0]  bresp_k = RESP_OKAY;
  int          aw_cnt, ar_cnt, w_cnt;
  bit          aw_got, w_got, ar_got, bvld, rvld;
  logic [31:0] slv_word;

  assign bus.m_AWREADY = bus.m_AWVALID && (aw_cnt >= aw_lat);
  assign bus.m_WREADY  = bus.m_WVALID && (!w_after_aw || (aw_got && (w_cnt >= w_gap)));
  assign bus.m_ARREADY = bus.m_ARVALID && (ar_cnt >= ar_lat);
  assign bus.m_BVALID  = bvld;
  assign bus.m_BRESP   = bresp_k;
  assign bus.m_RVALID  = rvld;
  assign bus.m_RDATA   = slv_word;
  assign bus.m_RRESP   = RESP_OKAY;

  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      aw_cnt <= 0; ar_cnt <= 0; w_cnt <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0; bvld <= 0; rvld <= 0;
      slv_word <= '0;
    end else begin
      aw_cnt <= (bus.m_AWVALID && !bus.m_AWREADY) ? aw_cnt + 1 : 0;
      ar_cnt <= (bus.m_ARVALID && !bus.m_ARREADY) ? ar_cnt + 1 : 0;
      if (bus.m_AWVALID && bus.m_AWREADY) begin
        aw_got <= 1; w_cnt <= 1;
      end else if (aw_got) begin
        w_cnt <= w_cnt + 1;
      end
      if (bus.m_WVALID && bus.m_WREADY) begin
        w_got <= 1;
        for (int b = 0; b < 4; b++)
          if (bus.m_WSTRB[b]) slv_word[8*b +: 8] <= bus.m_WDATA[8*b +: 8];
      end
      if (bvld && bus.m_BREADY) begin
        bvld <= 0; aw_got <= 0; w_got <= 0;
      end else if (!bvld && b_en && (aw_got || (bus.m_AWVALID && bus.m_AWREADY))
                   && (w_got || (bus.m_WVALID && bus.m_WREADY))) begin
        bvld <= 1;
      end
      if (bus.m_ARVALID && bus.m_ARREADY) ar_got <= 1;
      if (rvld && bus.m_RREADY) begin
        rvld <= 0; ar_got <= 0;
      end else if (!rvld && r_en && (ar_got || (bus.m_ARVALID && bus.m_ARREADY))) begin
        rvld <= 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge iCLK) begin
    if (bus.rsp_valid) begin
      mon_r.rdata = bus.rsp_rdata; mon_r.resp = bus.rsp_resp;
      mon_r.tmo = bus.rsp_timeout; mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
      rsp_cnt++;
    end
    if (bus.m_AWVALID && bus.m_AWREADY) begin aw_hs_cyc = cyc; aw_addr_seen = bus.m_AWADDR; end
    if (bus.m_WVALID && bus.m_WREADY) begin w_hs_cyc = cyc; w_data_seen = bus.m_WDATA; end
    if (bus.m_ARVALID && bus.m_ARREADY) begin ar_hs_cyc = cyc; ar_addr_seen = bus.m_ARADDR; end
    if (bus.m_RVALID && bus.m_RREADY) r_hs_cyc = cyc;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output int acc);
    @(posedge iCLK); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wstrb = strb;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      if (bus.req_ready) begin acc = cyc; break; end
    end
    @(posedge iCLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] resp, input logic tmo, input int c);
    rsp_t e;
    e.rdata = rdata; e.resp = resp; e.tmo = tmo; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_rsp(input int budget, output rsp_t e, output rsp_t o, output bit got);
    got = 0;
    e.rdata = '0; e.resp = '0; e.tmo = 0; e.cyc = -1;
    o = e;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge iCLK); #1;
      if (obs_q.size() > 0) got = 1;
    end
    if (got) o = obs_q.pop_front();
    if (exp_q.size() > 0) e = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge iCLK);
    #1;
    compared++;
    if ({bus.req_ready, bus.rsp_valid, bus.m_AWVALID, bus.m_WVALID, bus.m_BREADY, bus.m_ARVALID, bus.m_RREADY} !== 7'b0) begin
      mismatched++; $display("FAIL reset_handshakes got %b want 0000000",
        {bus.req_ready, bus.rsp_valid, bus.m_AWVALID, bus.m_WVALID, bus.m_BREADY, bus.m_ARVALID, bus.m_RREADY});
    end
    compared++;
    if ({bus.m_AWADDR, bus.m_ARADDR, bus.m_WDATA, bus.m_WSTRB} !== 100'b0) begin
      mismatched++; $display("FAIL reset_addr_data got %h %h %h %h want all 0", bus.m_AWADDR, bus.m_ARADDR, bus.m_WDATA, bus.m_WSTRB);
    end
    compared++;
    if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== 35'b0) begin
      mismatched++; $display("FAIL reset_rsp got %h %b %b want 0", bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout);
    end
    compared++;
    if ({bus.m_AWPROT, bus.m_ARPROT} !== 6'b0) begin
      mismatched++; $display("FAIL reset_prot got %b %b want 000", bus.m_AWPROT, bus.m_ARPROT);
    end
    iRST = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    int acc; rsp_t e, o; bit got;
    aw_hs_cyc = -1; w_hs_cyc = -1;
    issue(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, acc);
    push_exp(32'h0, RESP_OKAY, 1'b0, acc + 3);
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL wr0_rsp got none want rsp_valid (acc=%0d)", acc); end
    else begin
      compared++; if (o.cyc !== e.cyc) begin mismatched++; $display("FAIL wr0_lat got cycle %0d want %0d", o.cyc, e.cyc); end
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL wr0_resp got %b want %b", o.resp, e.resp); end
      compared++; if (o.tmo !== e.tmo) begin mismatched++; $display("FAIL wr0_tmo got %b want %b", o.tmo, e.tmo); end
      compared++; if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL wr0_rdata got %h want %h", o.rdata, e.rdata); end
    end
    compared++; if (aw_hs_cyc !== acc + 1) begin mismatched++; $display("FAIL wr0_aw_cyc got %0d want %0d", aw_hs_cyc, acc + 1); end
    compared++; if (w_hs_cyc !== acc + 1) begin mismatched++; $display("FAIL wr0_w_cyc got %0d want %0d", w_hs_cyc, acc + 1); end
    compared++; if (aw_addr_seen !== 32'h1000_0004) begin mismatched++; $display("FAIL wr0_awaddr got %h want 10000004", aw_addr_seen); end
    compared++; if (w_data_seen !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL wr0_wdata got %h want deadbeef", w_data_seen); end
  endtask

  task automatic test_read_delay();
    int acc; rsp_t e, o; bit got;
    ar_lat = 1; ar_hs_cyc = -1;
    issue(0, 32'h1000_0004, 32'h0, 4'h0, acc);
    push_exp(32'hDEAD_BEEF, RESP_OKAY, 1'b0, acc + 4);
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL rd_rsp got none want rsp_valid"); end
    else begin
      compared++; if (o.cyc !== e.cyc) begin mismatched++; $display("FAIL rd_lat got cycle %0d want %0d", o.cyc, e.cyc); end
      compared++; if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL rd_rdata got %h want %h", o.rdata, e.rdata); end
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL rd_resp got %b want %b", o.resp, e.resp); end
    end
    compared++; if (ar_hs_cyc !== acc + 2) begin mismatched++; $display("FAIL rd_ar_cyc got %0d want %0d", ar_hs_cyc, acc + 2); end
    compared++; if (ar_addr_seen !== 32'h1000_0004) begin mismatched++; $display("FAIL rd_araddr got %h want 10000004", ar_addr_seen); end
    ar_lat = 0;
  endtask

  task automatic test_w_after_aw();
    int acc, base; rsp_t e, o; bit got, seen_w;
    w_after_aw = 1; w_gap = 3; aw_hs_cyc = -1; w_hs_cyc = -1;
    base = rsp_cnt;
    issue(1, 32'h2000_0010, 32'hCAFE_F00D, 4'h3, acc);
    push_exp(32'h0, RESP_OKAY, 1'b0, acc + 6);
    seen_w = 0;
    for (int i = 0; i < 20 && !seen_w; i++) begin
      @(negedge iCLK); #1;
      compared++; if (bus.m_WVALID !== 1'b1) begin mismatched++; $display("FAIL waw_wvalid cycle %0d got %b want 1", cyc, bus.m_WVALID); end
      compared++; if (bus.m_WDATA !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL waw_wdata cycle %0d got %h want cafef00d", cyc, bus.m_WDATA); end
      if (bus.m_WREADY) seen_w = 1;
    end
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL waw_rsp got none want rsp_valid"); end
    else begin
      compared++; if (o.cyc !== e.cyc) begin mismatched++; $display("FAIL waw_lat got cycle %0d want %0d", o.cyc, e.cyc); end
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL waw_resp got %b want %b", o.resp, e.resp); end
    end
    compared++; if (w_hs_cyc - aw_hs_cyc !== 3) begin mismatched++; $display("FAIL waw_gap got %0d want 3", w_hs_cyc - aw_hs_cyc); end
    repeat (5) @(negedge iCLK);
    compared++; if (rsp_cnt - base !== 1) begin mismatched++; $display("FAIL waw_pulses got %0d want 1", rsp_cnt - base); end
    w_after_aw = 0; w_gap = 0;
  endtask

  task automatic test_bresp_decerr();
    int acc; rsp_t e, o; bit got;
    bresp_k = RESP_DECERR;
    issue(1, 32'h3000_0008, 32'h1234_5678, 4'hF, acc);
    push_exp(32'h0, RESP_DECERR, 1'b0, acc + 3);
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL dec_rsp got none want rsp_valid"); end
    else begin
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL dec_resp got %b want %b", o.resp, e.resp); end
      compared++; if (o.tmo !== e.tmo) begin mismatched++; $display("FAIL dec_tmo got %b want %b", o.tmo, e.tmo); end
    end
    bresp_k = RESP_OKAY;
  endtask

  task automatic test_timeout();
    int acc, base; rsp_t e, o; bit got;
    r_en = 0; r_hs_cyc = -1;
    issue(0, 32'h4000_0000, 32'h0, 4'h0, acc);
    push_exp(32'h0, RESP_SLVERR, 1'b1, acc + 17);
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL tmo_rsp got none want rsp_valid"); end
    else begin
      compared++; if (o.cyc !== e.cyc) begin mismatched++; $display("FAIL tmo_lat got cycle %0d want %0d", o.cyc, e.cyc); end
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL tmo_resp got %b want %b", o.resp, e.resp); end
      compared++; if (o.tmo !== e.tmo) begin mismatched++; $display("FAIL tmo_flag got %b want %b", o.tmo, e.tmo); end
      compared++; if (o.rdata !== e.rdata) begin mismatched++; $display("FAIL tmo_rdata got %h want %h", o.rdata, e.rdata); end
    end
    base = rsp_cnt;
    @(negedge iCLK); #1;
    compared++; if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL tmo_drain_block got req_ready=%b want 0", bus.req_ready); end
    compared++; if (bus.m_RREADY !== 1'b1) begin mismatched++; $display("FAIL tmo_drain_rready got %b want 1", bus.m_RREADY); end
    r_en = 1;
    for (int i = 0; i < 10 && r_hs_cyc < 0; i++) @(negedge iCLK);
    compared++; if (r_hs_cyc < 0) begin mismatched++; $display("FAIL tmo_drain_beat got no R handshake want one"); end
    repeat (4) @(negedge iCLK);
    #1;
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL tmo_after_drain got req_ready=%b want 1", bus.req_ready); end
    compared++; if (rsp_cnt - base !== 0) begin mismatched++; $display("FAIL tmo_second_rsp got %0d extra pulses want 0", rsp_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int acc, base; rsp_t e, o; bit got, in_b;
    b_en = 0; base = rsp_cnt;
    issue(1, 32'h5000_0000, 32'hA5A5_5A5A, 4'hF, acc);
    in_b = 0;
    for (int i = 0; i < 10 && !in_b; i++) begin
      @(negedge iCLK); #1;
      if (bus.m_BREADY) in_b = 1;
    end
    compared++; if (!in_b) begin mismatched++; $display("FAIL rstmid_reach got no BREADY want WRITE_RESP"); end
    iRST = 1'b0;
    #1;
    compared++;
    if ({bus.req_ready, bus.rsp_valid, bus.m_AWVALID, bus.m_WVALID, bus.m_BREADY, bus.m_ARVALID, bus.m_RREADY} !== 7'b0) begin
      mismatched++; $display("FAIL rstmid_handshakes got %b want 0000000",
        {bus.req_ready, bus.rsp_valid, bus.m_AWVALID, bus.m_WVALID, bus.m_BREADY, bus.m_ARVALID, bus.m_RREADY});
    end
    @(posedge iCLK); #1;
    compared++;
    if ({bus.rsp_valid, bus.m_BREADY, bus.m_AWADDR, bus.m_WDATA, bus.rsp_resp, bus.rsp_timeout} !== 70'b0) begin
      mismatched++; $display("FAIL rstmid_edge got rsp_valid=%b bready=%b awaddr=%h wdata=%h resp=%b tmo=%b want all 0",
        bus.rsp_valid, bus.m_BREADY, bus.m_AWADDR, bus.m_WDATA, bus.rsp_resp, bus.rsp_timeout);
    end
    @(negedge iCLK);
    iRST = 1'b1; b_en = 1;
    repeat (3) @(negedge iCLK);
    compared++; if (rsp_cnt - base !== 0) begin mismatched++; $display("FAIL rstmid_no_rsp got %0d pulses want 0", rsp_cnt - base); end
    issue(1, 32'h5000_0004, 32'h0BAD_F00D, 4'hF, acc);
    compared++; if (acc < 0) begin mismatched++; $display("FAIL rstmid_accept got no acceptance want accepted"); end
    push_exp(32'h0, RESP_OKAY, 1'b0, acc + 3);
    pop_rsp(40, e, o, got);
    compared++;
    if (!got) begin mismatched++; $display("FAIL rstmid_rsp got none want rsp_valid"); end
    else begin
      compared++; if (o.cyc !== e.cyc) begin mismatched++; $display("FAIL rstmid_lat got cycle %0d want %0d", o.cyc, e.cyc); end
      compared++; if (o.resp !== e.resp) begin mismatched++; $display("FAIL rstmid_resp got %b want %b", o.resp, e.resp); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_wstrb = '0;
    test_reset();
    test_write_zero_wait();
    test_read_delay();
    test_w_after_aw();
    test_bresp_decerr();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge iCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
